// File: rtl/axis_cpu_cmd_arbiter.sv
// axis_cpu_cmd_arbiter: round-robin packet arbiter that shares the single
// TREADY-less programming port of one axis_cpu among NUM_REQ command masters.
// It forwards granted words with one cycle of latency and routes cmd_out
// responses back to the owner of the most recent grant.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a grantee that stalls
// for TIMEOUT_CYCLES cycles is aborted and abort pulses for one cycle.
module axis_cpu_cmd_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_TDATA,
   input  logic [NUM_REQ-1:0]            req_TVALID,
   input  logic [NUM_REQ-1:0]            req_TLAST,
   output logic [NUM_REQ-1:0]            req_TREADY,
   output logic [DATA_WIDTH-1:0]         cmd_TDATA,
   output logic                          cmd_TVALID,
   input  logic [DATA_WIDTH-1:0]         rsp_TDATA,
   input  logic                          rsp_TVALID,
   output logic [DATA_WIDTH-1:0]         rsp_out_TDATA,
   output logic [NUM_REQ-1:0]            rsp_out_TVALID,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          abort
);

   localparam int OW = $clog2(NUM_REQ);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t                  state_q, state_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [OW-1:0]           owner_q, owner_d;
   logic [OW-1:0]           ptr_q, ptr_d;
   logic                    owner_valid_q, owner_valid_d;
   logic [DATA_WIDTH-1:0]   cmd_data_q, cmd_data_d;
   logic                    cmd_valid_q, cmd_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;

   logic                    win_found;
   logic [OW-1:0]           win_idx;
   logic [OW:0]             cand;
   logic                    xfer;
   logic                    xfer_last;
   logic                    stall_expired;
   logic [DATA_WIDTH-1:0]   grantee_data;

   // Round-robin search: first requester after the pointer, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (OW+1)'(k);
         if (cand >= (OW+1)'(NUM_REQ)) cand = cand - (OW+1)'(NUM_REQ);
         if (!win_found && req_TVALID[cand[OW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[OW-1:0];
         end
      end
   end

   // Grantee word select; the owner always equals the grantee while busy.
   always_comb begin
      grantee_data = req_TDATA[owner_q*DATA_WIDTH +: DATA_WIDTH];
      xfer         = (state_q == ST_BUSY) && |(req_TVALID & grant_q);
      xfer_last    = xfer && req_TLAST[owner_q];
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] stall_cnt_q, stall_cnt_d;
   logic          abort_q, abort_d;

   // Stall counter: counts grantee idle cycles, cleared by any transfer.
   always_comb begin
      stall_expired = (state_q == ST_BUSY) && !xfer &&
                      (stall_cnt_q == CW'(TIMEOUT_CYCLES - 1));
      if (state_q != ST_BUSY || xfer) stall_cnt_d = '0;
      else                            stall_cnt_d = stall_cnt_q + 1'b1;
      abort_d = stall_expired;
   end

   // Stall counter and abort pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         abort_q     <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         abort_q     <= abort_d;
      end
   end

   assign abort = abort_q;
`else
   assign stall_expired = 1'b0;
   assign abort         = 1'b0;
`endif

   // Next-state: grant in IDLE, forward words and release on TLAST in BUSY.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      ptr_d         = ptr_q;
      cmd_data_d    = cmd_data_q;
      cmd_valid_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d       = ST_BUSY;
               grant_d       = NUM_REQ'(1) << win_idx;
               owner_d       = win_idx;
               owner_valid_d = 1'b1;
            end
         end
         ST_BUSY: begin
            if (xfer) begin
               cmd_valid_d = 1'b1;
               cmd_data_d  = grantee_data;
            end
            if (xfer_last || stall_expired) begin
               state_d = ST_IDLE;
               grant_d = '0;
               ptr_d   = owner_q;
            end
            // An aborted packet leaves no owner for any late response.
            if (stall_expired) owner_valid_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Response steering uses the owner as registered before this cycle.
   always_comb begin
      rsp_data_d  = rsp_TDATA;
      rsp_valid_d = (rsp_TVALID && owner_valid_q) ? (NUM_REQ'(1) << owner_q) : '0;
   end

   // State, grant and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         ptr_q         <= OW'(NUM_REQ - 1);
         cmd_data_q    <= '0;
         cmd_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_valid_q   <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         ptr_q         <= ptr_d;
         cmd_data_q    <= cmd_data_d;
         cmd_valid_q   <= cmd_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_valid_q   <= rsp_valid_d;
      end
   end

   assign req_TREADY     = (state_q == ST_BUSY) ? grant_q : '0;
   assign grant          = grant_q;
   assign busy           = (state_q == ST_BUSY);
   assign cmd_TDATA      = cmd_data_q;
   assign cmd_TVALID     = cmd_valid_q;
   assign rsp_out_TDATA  = rsp_data_q;
   assign rsp_out_TVALID = rsp_valid_q;

endmodule

// File: tb/tb_axis_cpu_cmd_arbiter.sv
// Testbench for axis_cpu_cmd_arbiter with two masters. Masters replay queued
// words (bit 33 marks a one-cycle TVALID gap inside a packet, bit 32 is TLAST)
// and a packet-level reference model predicts every output each cycle.
module tb_axis_cpu_cmd_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] dat0 = '0, dat1 = '0;
   logic [N-1:0]  req_v = '0, req_l = '0;
   logic [N-1:0]  req_r;
   logic [DW-1:0] cmd_TDATA;
   logic          cmd_TVALID;
   logic          rsp_v = 1'b0;
   logic [DW-1:0] rsp_d = '0;
   logic [DW-1:0] rsp_out_TDATA;
   logic [N-1:0]  rsp_out_TVALID;
   logic [N-1:0]  grant;
   logic          busy;
   logic          abort;

   always #5 clk = ~clk;

   axis_cpu_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_TDATA({dat1, dat0}), .req_TVALID(req_v), .req_TLAST(req_l), .req_TREADY(req_r),
      .cmd_TDATA(cmd_TDATA), .cmd_TVALID(cmd_TVALID),
      .rsp_TDATA(rsp_d), .rsp_TVALID(rsp_v),
      .rsp_out_TDATA(rsp_out_TDATA), .rsp_out_TVALID(rsp_out_TVALID),
      .grant(grant), .busy(busy), .abort(abort)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // master stimulus queues
   logic [33:0] mq0[$];
   logic [33:0] mq1[$];
   bit rnd_stall = 0;
   bit rnd_rsp   = 0;

   function automatic int qsize(input int m);
      return (m == 0) ? mq0.size() : mq1.size();
   endfunction
   function automatic logic [33:0] qhead(input int m);
      if (m == 0) return mq0[0];
      return mq1[0];
   endfunction
   task automatic qpop(input int m);
      if (m == 0) void'(mq0.pop_front());
      else        void'(mq1.pop_front());
   endtask
   task automatic qpush(input int m, input logic [33:0] e);
      if (m == 0) mq0.push_back(e);
      else        mq1.push_back(e);
   endtask
   function automatic logic [33:0] word(input logic [31:0] d, input bit last);
      return {1'b0, last, d};
   endfunction
   localparam logic [33:0] GAP = {1'b1, 1'b0, 32'h0};

   // reference model: g = granted master or -1 when idle
   int g, ptr, owner, ov, stall;
   logic          e_cmd_v, e_abort;
   logic [DW-1:0] e_cmd_d, e_rsp_d;
   logic [N-1:0]  e_rsp_v;

   // observation logs for directed sequence checks
   logic [31:0] obs_cmd[$];
   logic [1:0]  obs_grant[$];
   logic [1:0]  prev_grant = '0;
   int          abort_cnt = 0;
   logic [31:0] expw[16];
   logic [1:0]  expg[8];

   task automatic model_reset();
      g = -1; ptr = N - 1; owner = 0; ov = 0; stall = 0;
      e_cmd_v = 0; e_cmd_d = '0; e_rsp_v = '0; e_rsp_d = '0; e_abort = 0;
   endtask

   task automatic drive();
      logic [33:0] h;
      logic v, l;
      logic [31:0] d;
      for (int m = 0; m < N; m++) begin
         v = 1'b0; d = $urandom; l = 1'($urandom_range(0, 1));
         if (qsize(m) > 0) begin
            h = qhead(m);
            if (!h[33] && !(rnd_stall && $urandom_range(0, 3) == 0)) begin
               v = 1'b1; d = h[31:0]; l = h[32];
            end
         end
         req_v[m] = v; req_l[m] = l;
         if (m == 0) dat0 = d; else dat1 = d;
      end
      if (rnd_rsp) begin
         rsp_v = 1'($urandom_range(0, 1));
         rsp_d = $urandom;
      end
   endtask

   task automatic model_step();
      int gb, acc, i;
      logic [33:0] h;
      gb = g; acc = -1;
      e_rsp_v = (rsp_v && ov != 0) ? 2'(1 << owner) : 2'b00;
      e_rsp_d = rsp_d;
      e_abort = 0;
      e_cmd_v = 0;
      if (g < 0) begin
         for (int k = 1; k <= N; k++) begin
            i = (ptr + k) % N;
            if (g < 0 && req_v[i]) begin
               g = i; owner = i; ov = 1; stall = 0;
            end
         end
      end else if (req_v[g]) begin
         e_cmd_v = 1; e_cmd_d = (g == 0) ? dat0 : dat1; acc = g; stall = 0;
         if (req_l[g]) begin ptr = g; g = -1; end
      end else begin
         stall++;
`ifdef ARB_TIMEOUT_EN
         if (stall == TO) begin e_abort = 1; ptr = g; g = -1; ov = 0; end
`endif
      end
      for (int m = 0; m < N; m++) begin
         if (acc == m) qpop(m);
         else if (gb == m && qsize(m) > 0) begin
            h = qhead(m);
            if (h[33]) qpop(m);
         end
      end
      if (e_abort) begin
         while (qsize(gb) > 0) begin
            h = qhead(gb);
            if (!h[33]) break;
            qpop(gb);
         end
      end
   endtask

   task automatic compare();
      logic [1:0] eg;
      eg = (g < 0) ? 2'b00 : 2'(1 << g);
      chk("grant", grant, eg);
      chk("busy", busy, g >= 0);
      chk("tready", req_r, eg);
      chk("cmd_valid", cmd_TVALID, e_cmd_v);
      chk("cmd_data", cmd_TDATA, e_cmd_d);
      chk("rsp_valid", rsp_out_TVALID, e_rsp_v);
      chk("rsp_data", rsp_out_TDATA, e_rsp_d);
      chk("abort", abort, e_abort);
      if (cmd_TVALID) obs_cmd.push_back(cmd_TDATA);
      if (grant != 0 && prev_grant == 0) obs_grant.push_back(grant);
      if (abort) abort_cnt++;
      prev_grant = grant;
   endtask

   task automatic cycle();
      drive();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic run_until_idle(input int maxc);
      int n;
      n = 0;
      while ((qsize(0) > 0 || qsize(1) > 0 || g >= 0) && n < maxc) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", n < maxc, 1'b1);
      cycle();
      cycle();
   endtask

   task automatic clear_logs();
      obs_cmd.delete();
      obs_grant.delete();
      abort_cnt = 0;
   endtask

   task automatic chk_words(input string tag, input int n);
      chk({tag, "_count"}, obs_cmd.size(), n);
      for (int i = 0; i < n && i < obs_cmd.size(); i++) chk(tag, obs_cmd[i], expw[i]);
   endtask

   task automatic chk_grants(input string tag, input int n);
      chk({tag, "_count"}, obs_grant.size(), n);
      for (int i = 0; i < n && i < obs_grant.size(); i++) chk(tag, obs_grant[i], expg[i]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare();
      @(negedge clk);
      rst = 1'b1;

      // response before any grant is dropped
      rsp_v = 1'b1; rsp_d = 32'hCAFE0001;
      cycle();
      chk("rsp_pregrant", rsp_out_TVALID, 2'b00);
      rsp_v = 1'b0;
      cycle();

      // three-word packet from master 0
      clear_logs();
      qpush(0, word(32'h11, 0)); qpush(0, word(32'h22, 0)); qpush(0, word(32'h33, 1));
      run_until_idle(50);
      expw[0] = 32'h11; expw[1] = 32'h22; expw[2] = 32'h33;
      chk_words("p1_words", 3);
      expg[0] = 2'b01;
      chk_grants("p1_grant", 1);

      // both masters stream 2-word packets; pointer now favours master 1
      clear_logs();
      for (int p = 0; p < 3; p++) begin
         qpush(0, word(32'hA0 + 2*p, 0)); qpush(0, word(32'hA1 + 2*p, 1));
         qpush(1, word(32'hB0 + 2*p, 0)); qpush(1, word(32'hB1 + 2*p, 1));
      end
      run_until_idle(100);
      for (int p = 0; p < 3; p++) begin
         expw[4*p]   = 32'hB0 + 2*p; expw[4*p+1] = 32'hB1 + 2*p;
         expw[4*p+2] = 32'hA0 + 2*p; expw[4*p+3] = 32'hA1 + 2*p;
         expg[2*p] = 2'b10; expg[2*p+1] = 2'b01;
      end
      chk_words("p2_words", 12);
      chk_grants("p2_grant", 6);

      // master 1 pauses three cycles mid-packet while master 0 waits
      clear_logs();
      qpush(1, word(32'hC0, 0)); qpush(1, GAP); qpush(1, GAP); qpush(1, GAP);
      qpush(1, word(32'hC1, 0)); qpush(1, word(32'hC2, 1));
      qpush(0, word(32'hD0, 1));
      run_until_idle(100);
      expw[0] = 32'hC0; expw[1] = 32'hC1; expw[2] = 32'hC2; expw[3] = 32'hD0;
      chk_words("p3_words", 4);
      expg[0] = 2'b10; expg[1] = 2'b01;
      chk_grants("p3_grant", 2);

      // response routed to master 1 after its packet
      qpush(1, word(32'hE0, 1));
      run_until_idle(50);
      rsp_v = 1'b1; rsp_d = 32'hDEADBEEF;
      cycle();
      chk("rsp_route_valid", rsp_out_TVALID, 2'b10);
      chk("rsp_route_data", rsp_out_TDATA, 32'hDEADBEEF);
      rsp_v = 1'b0;
      cycle();
      chk("rsp_route_clear", rsp_out_TVALID, 2'b00);

      // single-word packet
      clear_logs();
      qpush(0, word(32'h5, 1));
      run_until_idle(50);
      expw[0] = 32'h5;
      chk_words("p5_single", 1);

      // master 0 stalls after one word while master 1 waits
      clear_logs();
      qpush(0, word(32'h100, 0));
      cycle();
      for (int i = 0; i < 6; i++) qpush(0, GAP);
      qpush(0, word(32'h101, 1));
      qpush(1, word(32'h200, 1));
      run_until_idle(100);
`ifdef ARB_TIMEOUT_EN
      expw[0] = 32'h100; expw[1] = 32'h200; expw[2] = 32'h101;
      expg[0] = 2'b01; expg[1] = 2'b10; expg[2] = 2'b01;
      chk_words("p6_words", 3);
      chk_grants("p6_grant", 3);
      chk("p6_aborts", abort_cnt, 1);
`else
      expw[0] = 32'h100; expw[1] = 32'h101; expw[2] = 32'h200;
      expg[0] = 2'b01; expg[1] = 2'b10;
      chk_words("p6_words", 3);
      chk_grants("p6_grant", 2);
      chk("p6_aborts", abort_cnt, 0);
`endif

      // randomized traffic with stalls, gaps and responses
      rnd_stall = 1; rnd_rsp = 1;
      for (int p = 0; p < 30; p++) begin
         for (int m = 0; m < N; m++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int w = 0; w < len; w++) begin
               if (w > 0 && $urandom_range(0, 4) == 0) qpush(m, GAP);
               qpush(m, word($urandom, w == len - 1));
            end
         end
      end
      run_until_idle(4000);
      rnd_stall = 0; rnd_rsp = 0; rsp_v = 1'b0;

      // asynchronous reset in the middle of a packet
      qpush(0, word(32'h300, 0)); qpush(0, word(32'h301, 0)); qpush(0, word(32'h302, 1));
      cycle();
      cycle();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_valid", cmd_TVALID, 1'b0);
      mq0.delete(); mq1.delete();
      req_v = '0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cycle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
